// File: rtl/pipe_skid_reg_pkg.sv
// Shared pipeline definitions: skid-register state encoding and the bubble payload.
package pipe_skid_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_t;

  localparam logic [63:0] PIPE_NOP = 64'h0;

endpackage

// File: rtl/pipe_skid_reg.sv
// Two-entry registered skid buffer placed at each pipeline stage boundary.
// The state value doubles as the occupancy count; in_ready depends only on registered state.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int                 DATA_W    = 64,
  parameter logic [DATA_W-1:0]  FLUSH_VAL = DATA_W'(PIPE_NOP)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        occupancy
);

  skid_state_t       state_p0, state_nxt;
  logic [DATA_W-1:0] main_p0, main_nxt;
  logic [DATA_W-1:0] skid_p0, skid_nxt;
  logic              accept, pop;

  assign in_ready  = (state_p0 != ST_FULL);
  assign out_valid = (state_p0 != ST_EMPTY);
  assign out_data  = main_p0;
  assign occupancy = state_p0;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  always_comb begin
    state_nxt = state_p0;
    main_nxt  = main_p0;
    skid_nxt  = skid_p0;
    if (flush) begin
      // A pop in this cycle is still consumed downstream; an accept is dropped.
      state_nxt = ST_EMPTY;
      main_nxt  = FLUSH_VAL;
      skid_nxt  = FLUSH_VAL;
    end else begin
      unique case (state_p0)
        ST_EMPTY: begin
          if (accept) begin
            main_nxt  = in_data;
            state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            main_nxt = in_data;
          end else if (pop) begin
            state_nxt = ST_EMPTY;
          end else if (accept) begin
            skid_nxt  = in_data;
            state_nxt = ST_FULL;
          end
        end
        ST_FULL: begin
          if (pop) begin
            main_nxt  = skid_p0;
            state_nxt = ST_ONE;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Stage boundary: registered head/skid entries and occupancy state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= ST_EMPTY;
      main_p0  <= FLUSH_VAL;
      skid_p0  <= FLUSH_VAL;
    end else begin
      state_p0 <= state_nxt;
      main_p0  <= main_nxt;
      skid_p0  <= skid_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: directed scenarios followed by a random handshake run.
module tb_pipe_skid_reg;

  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready = 1'b0;
  logic [1:0]        occupancy;

  pipe_skid_reg #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] exp_q[$];
  int                mocc = 0;
  int                n_vec = 0;
  int                n_bad = 0;
  bit                mon_en = 1'b0;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus; the reference occupancy and expected-output queue advance on the edge.
  task automatic cyc(input bit v, input logic [DATA_W-1:0] d, input bit r, input bit f, input bit rs);
    bit acc, pp;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    rst       = rs;
    acc = v && (mocc != 2);
    pp  = (mocc != 0) && r;
    @(posedge clk);
    if (rs || f) begin
      mocc = 0;
      exp_q.delete();
    end else begin
      if (acc) exp_q.push_back(d);
      mocc = mocc + int'(acc) - int'(pp);
    end
    #1;
  endtask

  // Monitor: samples mid-cycle, pops the scoreboard on each handshake.
  always @(negedge clk) begin
    if (mon_en) begin
      check("occupancy", DATA_W'(occupancy), DATA_W'(mocc));
      check("out_valid", DATA_W'(out_valid), DATA_W'(mocc != 0));
      check("in_ready",  DATA_W'(in_ready),  DATA_W'(mocc != 2));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL out_unexpected: got 0x%0h, expected no output", out_data);
        end else if (out_ready) begin
          check("out_data_pop", out_data, exp_q.pop_front());
        end else begin
          check("out_data_stall", out_data, exp_q[0]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    cyc(0, '0, 0, 0, 1);
    mon_en = 1'b1;
    check("reset_out_data", out_data, '0);

    // First transaction: one-cycle latency
    cyc(1, 64'h00000013_00000004, 1, 0, 0);
    check("first_out_data", out_data, 64'h00000013_00000004);
    cyc(0, '0, 1, 0, 0);

    // Streaming at full throughput
    cyc(1, 64'h1, 1, 0, 0);
    cyc(1, 64'h2, 1, 0, 0);
    cyc(1, 64'h3, 1, 0, 0);
    cyc(0, '0, 1, 0, 0);
    cyc(0, '0, 1, 0, 0);

    // Stall: fill to FULL, 0xC held off, then drain in order
    cyc(1, 64'hA, 0, 0, 0);
    cyc(1, 64'hB, 0, 0, 0);
    cyc(1, 64'hC, 0, 0, 0);
    cyc(1, 64'hC, 0, 0, 0);
    cyc(1, 64'hC, 1, 0, 0);
    cyc(0, '0, 1, 0, 0);
    cyc(0, '0, 1, 0, 0);
    cyc(0, '0, 1, 0, 0);

    // Flush in FULL with a coincident offer of 0xD
    cyc(1, 64'hA, 0, 0, 0);
    cyc(1, 64'hB, 0, 0, 0);
    cyc(1, 64'hD, 0, 1, 0);
    check("flush_out_data", out_data, '0);
    cyc(0, '0, 1, 0, 0);
    cyc(0, '0, 1, 0, 0);

    // Reset in FULL with flush and in_valid also asserted
    cyc(1, 64'h55, 0, 0, 0);
    cyc(1, 64'h66, 0, 0, 0);
    cyc(1, 64'h77, 1, 1, 1);
    check("rst_full_out_data", out_data, '0);
    cyc(0, '0, 1, 0, 0);

    // Random handshakes with occasional flush
    for (int i = 0; i < 10000; i++) begin
      cyc(bit'($urandom_range(0, 1)), {$urandom, $urandom}, bit'($urandom_range(0, 1)),
          ($urandom_range(0, 63) == 0), 1'b0);
    end
    for (int i = 0; i < 4; i++) cyc(0, '0, 1, 0, 0);
    check("drain_empty", DATA_W'(exp_q.size()), '0);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
